// File: rtl/mul_pkg.sv
// Shared types and elaboration helpers for the iterative carry-save multiplier.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        CPA,
        DONE
    } state_t;

    function automatic int ceil_div(input int n, input int d);
        return (n + d - 1) / d;
    endfunction

    function automatic int prod_width(input int a_w, input int b_w);
        return a_w + b_w;
    endfunction

endpackage

// File: rtl/csa_3to2_vec.sv
// Bitwise 3:2 compressor vector; carry is pre-shifted left with cin in bit 0.
// Latency: combinational. Backpressure: none, pure datapath.
module csa_3to2_vec #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic [W-1:0] carry
);

    logic [W-2:0] maj;

    assign sum   = a ^ b ^ c;
    // The top majority bit would land at weight 2^W and is dropped (mod 2^W).
    assign maj   = (a[W-2:0] & b[W-2:0]) | (a[W-2:0] & c[W-2:0]) | (b[W-2:0] & c[W-2:0]);
    assign carry = {maj, cin};

endmodule

// File: rtl/mul_csa_iter.sv
// Iterative carry-save multiplier, ROWS partial-product rows folded per cycle.
// Latency: N_ITER+1 cycles from accept to out_valid.
// Backpressure: single transaction in flight; result held in DONE until out_ready.
module mul_csa_iter
    import mul_pkg::*;
#(
    parameter int A_W  = 16,
    parameter int B_W  = 9,
    parameter int ROWS = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_signed,
    input  logic [A_W-1:0]       in_a,
    input  logic [B_W-1:0]       in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [A_W+B_W-1:0]   out_result,
    output logic                 busy
);

    localparam int P_W    = prod_width(A_W, B_W);
    localparam int N_ITER = ceil_div(B_W, ROWS);
    localparam int IDX_W  = $clog2(B_W + ROWS + 1);

    state_t           state;
    logic [A_W-1:0]   a_reg;
    logic [B_W-1:0]   b_reg;
    logic             sgn_reg;
    logic [P_W-1:0]   sum_reg;
    logic [P_W-1:0]   carry_reg;
    logic [IDX_W-1:0] idx;

    logic [P_W-1:0]   a_ext;
    logic [P_W-1:0]   rows    [ROWS];
    logic [ROWS-1:0]  row_neg;
    logic [P_W-1:0]   st_sum  [ROWS+1];
    logic [P_W-1:0]   st_car  [ROWS+1];

    assign a_ext = sgn_reg ? {{B_W{a_reg[A_W-1]}}, a_reg} : {{B_W{1'b0}}, a_reg};

    // Signed mode: the multiplier MSB row has negative weight, so it is
    // inverted here and the +1 of the two's complement rides in as cin.
    always_comb begin
        for (int i = 0; i < ROWS; i++) begin
            rows[i]    = (a_ext & {P_W{|(b_reg & (B_W'(1) << (int'(idx) + i)))}})
                         << (int'(idx) + i);
            row_neg[i] = sgn_reg && ((int'(idx) + i) == (B_W - 1));
            if (row_neg[i]) begin
                rows[i] = ~rows[i];
            end
        end
    end

    assign st_sum[0] = sum_reg;
    assign st_car[0] = carry_reg;

    for (genvar g = 0; g < ROWS; g++) begin : g_csa
        csa_3to2_vec #(
            .W (P_W)
        ) u_csa (
            .a     (st_sum[g]),
            .b     (st_car[g]),
            .c     (rows[g]),
            .cin   (row_neg[g]),
            .sum   (st_sum[g+1]),
            .carry (st_car[g+1])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            a_reg      <= '0;
            b_reg      <= '0;
            sgn_reg    <= 1'b0;
            sum_reg    <= '0;
            carry_reg  <= '0;
            idx        <= '0;
            in_ready   <= 1'b0;
            busy       <= 1'b0;
            out_valid  <= 1'b0;
            out_result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        a_reg     <= in_a;
                        b_reg     <= in_b;
                        sgn_reg   <= in_signed;
                        sum_reg   <= '0;
                        carry_reg <= '0;
                        idx       <= '0;
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
                        state     <= ACC;
                    end
                end
                ACC: begin
                    sum_reg   <= st_sum[ROWS];
                    carry_reg <= st_car[ROWS];
                    idx       <= idx + IDX_W'(ROWS);
                    if (idx == IDX_W'((N_ITER - 1) * ROWS)) begin
                        state <= CPA;
                    end
                end
                CPA: begin
                    out_result <= sum_reg + carry_reg;
                    out_valid  <= 1'b1;
                    state      <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_csa_iter.sv
// Self-checking bench: directed cases on the default configuration plus a
// randomized parameter sweep checked against a plain-arithmetic multiply.
module tb_mul_csa_iter;

    localparam int A_W    = 16;
    localparam int B_W    = 9;
    localparam int P_W    = 25;
    localparam int N_ITER = 3;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic           in_signed = 1'b0;
    logic [A_W-1:0] in_a = '0;
    logic [B_W-1:0] in_b = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [P_W-1:0] out_result;
    logic           busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic sw_go = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mul_csa_iter dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_signed  (in_signed),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .busy       (busy)
    );

    function automatic logic [P_W-1:0] ref_mul(input logic [A_W-1:0] a, input logic [B_W-1:0] b,
                                               input logic s);
        longint pa, pb, pp;
        pa = s ? longint'($signed(a)) : longint'(a);
        pb = s ? longint'($signed(b)) : longint'(b);
        pp = pa * pb;
        return pp[P_W-1:0];
    endfunction

    // Drives one transaction with out_ready held high; reports result, latency, accept cycle.
    task automatic do_op(input logic [A_W-1:0] a, input logic [B_W-1:0] b, input logic s,
                         output logic [P_W-1:0] res, output int lat, output int acc_cyc);
        int n;
        in_a = a; in_b = b; in_signed = s; in_valid = 1'b1; out_ready = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        acc_cyc = cyc;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        res = out_result;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
        checks++; if (out_result !== '0) begin errors++; $display("FAIL rst_out_result: got %h expected 0", out_result); end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_unsigned;
        logic [P_W-1:0] res; int lat, ac;
        do_op(16'hFFFF, 9'h1FF, 1'b0, res, lat, ac);
        checks++; if (res !== 25'h1FEFE01) begin errors++; $display("FAIL unsigned_max: got %h expected 1fefe01", res); end
        checks++; if (lat !== N_ITER + 1) begin errors++; $display("FAIL unsigned_latency: got %0d expected %0d", lat, N_ITER + 1); end
    endtask

    task automatic test_signed;
        logic [P_W-1:0] res; int lat, ac;
        do_op(16'h8000, 9'h100, 1'b1, res, lat, ac);
        checks++; if (res !== 25'h0800000) begin errors++; $display("FAIL signed_minmin: got %h expected 0800000", res); end
        do_op(16'hFFFF, 9'h003, 1'b1, res, lat, ac);
        checks++; if (res !== 25'h1FFFFFD) begin errors++; $display("FAIL signed_neg1x3: got %h expected 1fffffd", res); end
        do_op(16'hFFFF, 9'h003, 1'b0, res, lat, ac);
        checks++; if (res !== 25'h002FFFD) begin errors++; $display("FAIL unsigned_ffffx3: got %h expected 002fffd", res); end
    endtask

    task automatic test_backpressure;
        logic [P_W-1:0] expv; int n;
        expv = ref_mul(16'h1234, 9'h0AB, 1'b1);
        out_ready = 1'b0;
        in_a = 16'h1234; in_b = 9'h0AB; in_signed = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_rise: got %b expected 1", out_valid); end
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin in_valid = 1'b1; in_a = 16'h0007; in_b = 9'h003; in_signed = 1'b0; end
            if (i == 5) in_valid = 1'b0;
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid: cycle %0d got %b expected 1", i, out_valid); end
            checks++; if (out_result !== expv) begin errors++; $display("FAIL bp_hold_result: cycle %0d got %h expected %h", i, out_result, expv); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: cycle %0d got %b expected 0", i, in_ready); end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b expected 1", in_ready); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_no_queue: busy got %b expected 0", busy); end
    endtask

    task automatic test_reset_mid;
        logic [P_W-1:0] res; int lat, ac;
        in_a = 16'h00FF; in_b = 9'h0FF; in_signed = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %b expected 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        checks++; if (out_result !== '0) begin errors++; $display("FAIL midrst_out_result: got %h expected 0", out_result); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready: got %b expected 1", in_ready); end
        do_op(16'd3, 9'd5, 1'b0, res, lat, ac);
        checks++; if (res !== 25'd15) begin errors++; $display("FAIL midrst_3x5: got %0d expected 15", res); end
    endtask

    task automatic test_zero_identity;
        logic [P_W-1:0] res; int lat, ac;
        for (int s = 0; s < 2; s++) begin
            do_op(16'h0000, 9'h1FF, 1'(s), res, lat, ac);
            checks++; if (res !== '0) begin errors++; $display("FAIL zero_a: mode %0d got %h expected 0", s, res); end
            do_op(16'h1234, 9'h001, 1'(s), res, lat, ac);
            checks++; if (res !== 25'h0001234) begin errors++; $display("FAIL identity_b: mode %0d got %h expected 0001234", s, res); end
        end
    endtask

    task automatic test_back_to_back;
        logic [P_W-1:0] res, expv; logic [A_W-1:0] a; logic [B_W-1:0] b; logic s;
        int lat, ac, prev_ac;
        prev_ac = 0;
        for (int i = 0; i < 40; i++) begin
            a = 16'($urandom); b = 9'($urandom); s = 1'($urandom_range(0, 1));
            expv = ref_mul(a, b, s);
            do_op(a, b, s, res, lat, ac);
            checks++; if (res !== expv) begin errors++; $display("FAIL b2b_result: a=%h b=%h s=%0d got %h expected %h", a, b, s, res, expv); end
            checks++; if (lat !== N_ITER + 1) begin errors++; $display("FAIL b2b_latency: got %0d expected %0d", lat, N_ITER + 1); end
            if (i > 0) begin
                checks++; if (ac - prev_ac !== N_ITER + 3) begin errors++; $display("FAIL b2b_interval: got %0d expected %0d", ac - prev_ac, N_ITER + 3); end
            end
            prev_ac = ac;
        end
    endtask

    localparam int NCFG = 3;
    localparam int CAW[NCFG] = '{8, 8, 12};
    localparam int CBW[NCFG] = '{8, 8, 5};
    localparam int CRW[NCFG] = '{1, 8, 2};

    for (genvar g = 0; g < NCFG; g++) begin : g_sw
        localparam int AW = CAW[g];
        localparam int BW = CBW[g];
        localparam int RW = CRW[g];
        localparam int PW = AW + BW;
        localparam int NI = (BW + RW - 1) / RW;

        logic          iv = 1'b0;
        logic          ir;
        logic          sg = 1'b0;
        logic [AW-1:0] a = '0;
        logic [BW-1:0] b = '0;
        logic          ov;
        logic          orr = 1'b0;
        logic [PW-1:0] r;
        logic          bz;
        logic          done_f = 1'b0;

        mul_csa_iter #(
            .A_W  (AW),
            .B_W  (BW),
            .ROWS (RW)
        ) dut_sw (
            .clk        (clk),
            .rst        (rst),
            .in_valid   (iv),
            .in_ready   (ir),
            .in_signed  (sg),
            .in_a       (a),
            .in_b       (b),
            .out_valid  (ov),
            .out_ready  (orr),
            .out_result (r),
            .busy       (bz)
        );

        initial begin : run
            int n, lat;
            logic hs;
            logic [PW-1:0] expv;
            longint pa, pb, pp;
            wait (sw_go);
            for (int t = 0; t < 2000; t++) begin
                a = AW'($urandom); b = BW'($urandom); sg = 1'($urandom_range(0, 1));
                pa = sg ? longint'($signed(a)) : longint'(a);
                pb = sg ? longint'($signed(b)) : longint'(b);
                pp = pa * pb;
                expv = pp[PW-1:0];
                iv = 1'b1;
                n = 0;
                while (!ir && n < 100) begin @(posedge clk); #1; n++; end
                @(posedge clk); #1;
                iv = 1'b0;
                lat = 0;
                while (!ov && lat < 100) begin @(posedge clk); #1; lat++; end
                checks++; if (lat !== NI + 1) begin errors++; $display("FAIL sweep%0d_latency: got %0d expected %0d", g, lat, NI + 1); end
                checks++; if (r !== expv) begin errors++; $display("FAIL sweep%0d_result: a=%h b=%h s=%0d got %h expected %h", g, a, b, sg, r, expv); end
                hs = 1'b0; n = 0;
                while (!hs && n < 100) begin
                    orr = 1'($urandom_range(0, 1));
                    hs = orr;
                    @(posedge clk); #1;
                    n++;
                end
                orr = 1'b0;
            end
            done_f = 1'b1;
        end
    end

    task automatic test_sweep;
        int n;
        sw_go = 1'b1;
        n = 0;
        while (!(g_sw[0].done_f && g_sw[1].done_f && g_sw[2].done_f) && n < 60000) begin
            @(posedge clk); n++;
        end
        checks++;
        if (!(g_sw[0].done_f && g_sw[1].done_f && g_sw[2].done_f)) begin
            errors++; $display("FAIL sweep_timeout: got %0d cycles expected completion", n);
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_backpressure();
        test_reset_mid();
        test_zero_identity();
        test_back_to_back();
        test_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul_csa_iter.md
# mul_csa_iter

Parametrised, iterative carry-save multiplier. It generalises the fixed 16x9 combinational array multiplier to configurable operand widths and adds a per-transaction signed/unsigned mode. Each cycle it folds a configurable number of partial-product rows into registered sum/carry vectors, then resolves them with one final carry-propagate add. It sits behind a valid/ready handshake on both sides and is a drop-in arithmetic unit for datapaths that trade latency for area.

## Interface
- A_W, default 16: width of multiplicand in_a (>= 2).
- B_W, default 9: width of multiplier in_b (>= 2).
- ROWS, default 3: partial-product rows reduced per cycle (1..B_W).
- P_W, derived as A_W+B_W: result width (localparam).
- N_ITER, derived as ceil(B_W/ROWS): accumulate cycles (localparam).
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand transfer request.
- in_ready  out  1  block can accept operands.
- in_signed  in  1  1 = both operands two's complement; 0 = both unsigned.
- in_a  in  A_W  multiplicand.
- in_b  in  B_W  multiplier.
- out_valid  out  1  out_result holds a finished product.
- out_ready  in  1  consumer accepts the result.
- out_result  out  P_W  product.
- busy  out  1  high whenever state is not IDLE.

## Operation
- States: IDLE, ACC, CPA, DONE.
- IDLE: in_ready=1. On in_valid: latch in_a, in_b and in_signed; clear the sum and carry registers (P_W each) and the row index; go to ACC.
- ACC: each cycle, add rows idx..idx+ROWS-1 into sum/carry through a chain of 3:2 compressors. Row j is (A_ext & {P_W{b[j]}}) << j. A_ext is A zero-extended in unsigned mode and sign-extended in signed mode. Rows with j >= B_W contribute 0. After N_ITER cycles, go to CPA.
- Signed mode: row B_W-1 is subtracted, not added. Invert the shifted row and inject +1 into a free carry bit 0 in that cycle.
- CPA: out_result <= sum + carry, mod 2^P_W. Set out_valid; go to DONE.
- DONE: hold out_result and out_valid until out_ready. Then clear out_valid and go to IDLE.
- in_ready is 0 outside IDLE. Inputs presented then are ignored and not queued.
- Arithmetic: out_result equals the exact product in the selected mode, as P_W-bit two's complement or unsigned. No overflow is possible, including (-2^(A_W-1)) x (-2^(B_W-1)).
- Reset (async, any state, including mid-ACC): state=IDLE. out_valid=0, out_result=0, busy=0, sum/carry/index=0. in_ready=1 from the first edge after reset deasserts. An in-flight operation is discarded.

## Timing
- Operand accept happens at the rising edge where in_valid && in_ready; call it edge k.
- out_valid rises after edge k+N_ITER+1. Latency is N_ITER+1 cycles; with defaults (N_ITER=3) that is 4.
- The result handshake completes at the edge where out_valid && out_ready. in_ready is high the following cycle.
- The minimum initiation interval is N_ITER+3 cycles when out_ready is held high.
- If out_ready is already high when out_valid rises, DONE lasts exactly one cycle.
- out_result is stable from out_valid rising until the handshake. Its value in other states is don't-care but must not be X after reset.
- No combinational path from any input to any output. in_ready, out_valid and busy decode registered state only.

## Structure
- Shared package mul_pkg holds:
  - the state enum (IDLE, ACC, CPA, DONE);
  - a ceil-div function used for N_ITER;
  - a function computing P_W.
- One sub-module, csa_3to2_vec: parametrised width W, purely combinational bitwise full-adder vector. Outputs are sum and a carry vector shifted left by one, with carry[0] = a cin input used for the signed +1.
- The top instantiates ROWS csa_3to2_vec stages chained per cycle, then the FSM, operand/row-index registers and the final adder.

## Test plan
- Unsigned, defaults: a=0xFFFF, b=0x1FF, signed=0. out_result=0x1FEFE01. out_valid rises exactly 4 cycles after accept.
- Signed, defaults: a=0x8000, b=0x100, signed=1. out_result=0x0800000. Then a=0xFFFF, b=0x003: signed=1 gives 0x1FFFFFD; signed=0 gives 0x002FFFD.
- Back-pressure: hold out_ready=0 for 10 cycles after out_valid. out_result and out_valid are stable, in_ready=0, and a competing in_valid pulse is ignored. Raise out_ready: handshake completes and in_ready=1 the next cycle.
- Reset mid-operation: assert rst during the 2nd ACC cycle. All outputs return to reset values immediately, in_ready=1 after release, and a new operation 3x5 gives 15.
- Zero/identity: a=0 with b=0x1FF, and a=0x1234 with b=0x001, in both modes. Results are 0 and 0x1234 (signed: 0x0001234).
- Parameter sweep: (A_W,B_W,ROWS) = (8,8,1), (8,8,8), (12,5,2). Run 2000 random transactions per configuration in both modes with random out_ready. Compare against a behavioural multiply. Latency equals N_ITER+1 in every transaction.
